sm_clk_gate_ctrl_mc: RTL

Multi-channel successor to the single-SM clock-enable controller. It owns one clock-enable per SM and gates each SM after a run-time programmable idle threshold. It staggers wake-ups through a round-robin arbiter to bound the di/dt current step. Each channel has a settle window before it reports ready to the work dispatcher. The block sits between the global work scheduler (activity sources) and the SM clock-gating cells.

---
 rtl/sm_clk_gate_ctrl_mc_pkg.sv | 32 +++
 rtl/sm_clk_gate_ctrl_mc_if.sv | 53 +++++
 rtl/sm_clk_gate_ch.sv | 108 ++++++++++
 rtl/sm_clk_gate_ctrl_mc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sm_clk_gate_ctrl_mc_pkg.sv
// -----------------------------------------------------------------------------
// sm_clk_gate_ctrl_mc_pkg
// Shared types and helpers for the multi-channel SM clock-gate controller.
//   ch_state_t     : per-channel state (OFF, WAKE_REQ, WAKE, ON)
//   min1_clog2()   : counter width helper that never returns 0
//   DEF_*          : default parameter values shared by top and interface
// -----------------------------------------------------------------------------
package sm_clk_gate_ctrl_mc_pkg;

   // OFF      : SM clock stopped, nothing pending
   // WAKE_REQ : wake wanted, waiting for an arbiter grant (sticky)
   // WAKE     : clock enabled, waiting for the SM clock tree to settle
   // ON       : clock enabled and settled, idle counter running
   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_WAKE_REQ = 2'd1,
      ST_WAKE     = 2'd2,
      ST_ON       = 2'd3
   } ch_state_t;

   localparam int DEF_N_CH     = 8;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_WAKE_DLY = 4;
   localparam int DEF_WAKE_GAP = 2;

   // Width needed to hold 0 .. n-1. A counter that only ever holds 0
   // (n == 1) still gets one bit so that vectors are never zero-width.
   function automatic int min1_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sm_clk_gate_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// sm_clk_gate_ctrl_mc_if
// Bundle between the work scheduler and the clock-gate controller.
//   gate_en      : global gating enable (0 forces every channel awake)
//   idle_thresh  : idle cycles tolerated before a channel is gated
//   activity     : per-channel work-issue pulse or level
//   force_on     : per-channel gating veto
//   clk_en       : per-channel clock enable to the SM gating cells
//   ch_ready     : per-channel "clock settled, accept work"
//   wake_pending : some channel is waiting for a wake grant
//   all_gated    : every channel is OFF
// master : scheduler side (drives requests, observes status)
// slave  : controller side
// -----------------------------------------------------------------------------
interface sm_clk_gate_ctrl_mc_if
   import sm_clk_gate_ctrl_mc_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int CNT_W = DEF_CNT_W
);

   logic              gate_en;
   logic [CNT_W-1:0]  idle_thresh;
   logic [N_CH-1:0]   activity;
   logic [N_CH-1:0]   force_on;
   logic [N_CH-1:0]   clk_en;
   logic [N_CH-1:0]   ch_ready;
   logic              wake_pending;
   logic              all_gated;

   modport master (
      output gate_en,
      output idle_thresh,
      output activity,
      output force_on,
      input  clk_en,
      input  ch_ready,
      input  wake_pending,
      input  all_gated
   );

   modport slave (
      input  gate_en,
      input  idle_thresh,
      input  activity,
      input  force_on,
      output clk_en,
      output ch_ready,
      output wake_pending,
      output all_gated
   );

endinterface

// File: rtl/sm_clk_gate_ch.sv
// -----------------------------------------------------------------------------
// sm_clk_gate_ch
// One SM channel: state machine, idle counter and settle counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wake         : combined wake condition (activity | force_on | ~gate_en)
//   idle_thresh  : idle cycles before gating, compared live every cycle
//   grant        : one-cycle wake grant from the shared arbiter
//   req          : channel is in WAKE_REQ (combinational from state register)
//   state_next   : next state, used by the top for the summary flags
//   clk_en       : registered clock enable (WAKE or ON)
//   ch_ready     : registered settled flag (ON only)
// -----------------------------------------------------------------------------
module sm_clk_gate_ch
   import sm_clk_gate_ctrl_mc_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WAKE_DLY = DEF_WAKE_DLY
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wake,
   input  logic [CNT_W-1:0] idle_thresh,
   input  logic             grant,
   output logic             req,
   output ch_state_t        state_next,
   output logic             clk_en,
   output logic             ch_ready
);

   localparam int SET_W = min1_clog2(WAKE_DLY);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(WAKE_DLY - 1);
   localparam logic [CNT_W-1:0] IDLE_MAX    = '1;

   ch_state_t        state_reg;
   logic [CNT_W-1:0] idle_cnt_reg;
   logic [CNT_W-1:0] idle_cnt_next;
   logic [SET_W-1:0] settle_cnt_reg;
   logic [SET_W-1:0] settle_cnt_next;
   logic             clk_en_reg;
   logic             ch_ready_reg;

   // State and counters. The outputs are registered from the next state so
   // that clk_en rises on the same edge the channel enters WAKE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_OFF;
         idle_cnt_reg   <= '0;
         settle_cnt_reg <= '0;
         clk_en_reg     <= 1'b0;
         ch_ready_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idle_cnt_reg   <= idle_cnt_next;
         settle_cnt_reg <= settle_cnt_next;
         clk_en_reg     <= (state_next == ST_WAKE) || (state_next == ST_ON);
         ch_ready_reg   <= (state_next == ST_ON);
      end
   end

   always_comb begin
      state_next      = state_reg;
      idle_cnt_next   = idle_cnt_reg;
      settle_cnt_next = settle_cnt_reg;
      unique case (state_reg)
         ST_OFF: begin
            if (wake) begin
               state_next = ST_WAKE_REQ;
            end
         end
         ST_WAKE_REQ: begin
            // Sticky: only a grant moves us on, a dropped wake does not.
            if (grant) begin
               state_next      = ST_WAKE;
               settle_cnt_next = '0;
            end
         end
         ST_WAKE: begin
            // Activity is irrelevant while the clock tree settles.
            if (settle_cnt_reg == SETTLE_LAST) begin
               state_next    = ST_ON;
               idle_cnt_next = '0;
            end else begin
               settle_cnt_next = settle_cnt_reg + 1'b1;
            end
         end
         ST_ON: begin
            // Wake has priority over a threshold hit in the same cycle.
            if (wake) begin
               idle_cnt_next = '0;
            end else if (idle_cnt_reg >= idle_thresh) begin
               state_next = ST_OFF;
            end else if (idle_cnt_reg != IDLE_MAX) begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_OFF;
         end
      endcase
   end

   assign req      = (state_reg == ST_WAKE_REQ);
   assign clk_en   = clk_en_reg;
   assign ch_ready = ch_ready_reg;

endmodule

// File: rtl/sm_clk_gate_ctrl_mc.sv
// -----------------------------------------------------------------------------
// sm_clk_gate_ctrl_mc
// Multi-channel SM clock-enable controller. Each channel gates its SM after a
// programmable idle period; wake-ups are staggered through a round-robin
// arbiter with a minimum gap between grants to limit the supply current step.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (overrides everything)
//   bus  : slave side of sm_clk_gate_ctrl_mc_if (requests in, status out)
// -----------------------------------------------------------------------------
module sm_clk_gate_ctrl_mc
   import sm_clk_gate_ctrl_mc_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WAKE_DLY = DEF_WAKE_DLY,
   parameter int WAKE_GAP = DEF_WAKE_GAP
)
(
   input  logic                 clk,
   input  logic                 rst,
   sm_clk_gate_ctrl_mc_if.slave bus
);

   localparam int PTR_W = min1_clog2(N_CH);
   localparam int GAP_W = min1_clog2(WAKE_GAP);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WAKE_GAP - 1);

   logic [N_CH-1:0]  wake;
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  clk_en_vec;
   logic [N_CH-1:0]  ch_ready_vec;
   ch_state_t        st_next [N_CH];

   logic [PTR_W-1:0] rr_ptr_reg;
   logic [PTR_W-1:0] rr_ptr_next;
   logic [GAP_W-1:0] gap_reg;
   logic [GAP_W-1:0] gap_next;
   logic             grant_vld;
   logic [PTR_W-1:0] grant_idx;

   logic             wake_pending_reg;
   logic             all_gated_reg;
   logic             any_req_next;
   logic             all_off_next;

   // ---------------------------------------------------------------------
   // Channels
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign wake[gi] = bus.activity[gi] | bus.force_on[gi] | ~bus.gate_en;

         sm_clk_gate_ch #(
            .CNT_W    (CNT_W),
            .WAKE_DLY (WAKE_DLY)
         ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wake        (wake[gi]),
            .idle_thresh (bus.idle_thresh),
            .grant       (grant[gi]),
            .req         (req[gi]),
            .state_next  (st_next[gi]),
            .clk_en      (clk_en_vec[gi]),
            .ch_ready    (ch_ready_vec[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Round-robin arbiter. The search from the pointer is split into two
   // passes (indices at/above the pointer, then below it) so the priority
   // rotation needs no modulo arithmetic on the index.
   // ---------------------------------------------------------------------
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      if (gap_reg == '0) begin
         for (int c = 0; c < N_CH; c++) begin
            if (!grant_vld && req[c] && (c >= int'(rr_ptr_reg))) begin
               grant_vld = 1'b1;
               grant_idx = PTR_W'(c);
               grant[c]  = 1'b1;
            end
         end
         for (int c = 0; c < N_CH; c++) begin
            if (!grant_vld && req[c] && (c < int'(rr_ptr_reg))) begin
               grant_vld = 1'b1;
               grant_idx = PTR_W'(c);
               grant[c]  = 1'b1;
            end
         end
      end
   end

   // Pointer moves past the winner; the gap timer blocks further grants for
   // WAKE_GAP-1 cycles after each grant.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      gap_next    = gap_reg;
      if (grant_vld) begin
         rr_ptr_next = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
         gap_next    = GAP_LOAD;
      end else if (gap_reg != '0) begin
         gap_next = gap_reg - 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Summary flags, taken from next state so they line up with clk_en.
   // ---------------------------------------------------------------------
   always_comb begin
      any_req_next = 1'b0;
      all_off_next = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if (st_next[c] == ST_WAKE_REQ) begin
            any_req_next = 1'b1;
         end
         if (st_next[c] != ST_OFF) begin
            all_off_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg       <= '0;
         gap_reg          <= '0;
         wake_pending_reg <= 1'b0;
         all_gated_reg    <= 1'b1;
      end else begin
         rr_ptr_reg       <= rr_ptr_next;
         gap_reg          <= gap_next;
         wake_pending_reg <= any_req_next;
         all_gated_reg    <= all_off_next;
      end
   end

   assign bus.clk_en       = clk_en_vec;
   assign bus.ch_ready     = ch_ready_vec;
   assign bus.wake_pending = wake_pending_reg;
   assign bus.all_gated    = all_gated_reg;

endmodule
